// File: rtl/alu_uart_pkg.sv
// rtl/alu_uart_pkg.sv - shared constants, state type and hex helper for the ALU result UART
package alu_uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase)
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer
// Ports: clk, reset (async, active-high), data/load (byte accepted when idle or
// in the final stop-bit cycle), txd (registered line), done (high during the
// final stop-bit cycle), busy (high while a character is on the line).
module uart_tx_byte
    import alu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       load,
    output logic       txd,
    output logic       done,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          txd_q, txd_n;
    logic          busy_q, busy_n;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign done     = (state == STOP) && baud_end;
    assign txd      = txd_q;
    assign busy     = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            txd_q    <= txd_n;
            busy_q   <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        txd_n      = txd_q;
        busy_n     = busy_q;
        case (state)
            IDLE: begin
                if (load) begin
                    state_n    = START;
                    baud_cnt_n = '0;
                    shreg_n    = data;
                    txd_n      = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_n    = DATA;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    txd_n      = shreg[0];
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        // shift so the next bit is always shreg[0] after the edge
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        txd_n     = shreg[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    // a load here chains the next start bit with no idle gap
                    if (load) begin
                        state_n = START;
                        shreg_n = data;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        txd_n   = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// rtl/alu_result_uart_tx.sv - captures the ALU result and sends it as raw byte or "HH\r\n"
// Ports: clk, reset (async, active-high), result (sampled on accepted start),
// tx_start (level or pulse), busy (registered frame-in-progress), txd (UART out).
module alu_result_uart_tx
    import alu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int ASCII_HEX    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] result,
    input  logic       tx_start,
    output logic       busy,
    output logic       txd
);

    localparam logic [1:0] LAST_CHAR = (ASCII_HEX != 0) ? 2'd3 : 2'd0;

    logic [7:0] held;
    logic [1:0] char_idx;
    logic       busy_q;
    logic       byte_busy;
    logic       byte_done;
    logic       accept;
    logic       advance;
    logic       load;
    logic [7:0] load_data;

    function automatic logic [7:0] char_at(input logic [7:0] word, input logic [1:0] idx);
        if (ASCII_HEX == 0) begin
            return word;
        end
        case (idx)
            2'd0:    return nibble_to_ascii(word[7:4]);
            2'd1:    return nibble_to_ascii(word[3:0]);
            2'd2:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    assign accept  = tx_start && !busy_q && !byte_busy;
    assign advance = busy_q && byte_done && (char_idx != LAST_CHAR);
    assign load    = accept || advance;
    // the first character comes straight from result so the start bit
    // appears on the accepting edge; later ones come from the held copy
    assign load_data = accept ? char_at(result, 2'd0) : char_at(held, char_idx + 2'd1);
    assign busy      = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held     <= '0;
            char_idx <= '0;
            busy_q   <= 1'b0;
        end else if (accept) begin
            held     <= result;
            char_idx <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q && byte_done) begin
            if (advance) begin
                char_idx <= char_idx + 2'd1;
            end else begin
                char_idx <= '0;
                busy_q   <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk  (clk),
        .reset(reset),
        .data (load_data),
        .load (load),
        .txd  (txd),
        .done (byte_done),
        .busy (byte_busy)
    );

endmodule
